// File: rtl/uart_mike_tx_if.sv
// uart_mike_tx_if: MMIO-side control/status bundle for the UART transmit engine.
//   tx_data     - byte to transmit (level from the register block)
//   tx_send     - send request level; the engine starts on its rising edge
//   tx_flag_clr - clears the sticky completion flag while high
//   tx_flag     - sticky frame-complete flag
//   tx_busy     - high while a frame is in progress
// master: register block side; slave: transmit engine side.
interface uart_mike_tx_if #(
    parameter int unsigned DATA_W = 8
);
    logic [DATA_W-1:0] tx_data;
    logic              tx_send;
    logic              tx_flag_clr;
    logic              tx_flag;
    logic              tx_busy;

    modport master (
        output tx_data,
        output tx_send,
        output tx_flag_clr,
        input  tx_flag,
        input  tx_busy
    );

    modport slave (
        input  tx_data,
        input  tx_send,
        input  tx_flag_clr,
        output tx_flag,
        output tx_busy
    );
endinterface

// File: rtl/uart_mike_tx.sv
// uart_mike_tx: UART transmit engine fed by the MMIO register block.
// Serialises one frame per tx_send rising edge: start bit, DATA_W data bits LSB first,
// optional parity bit, STOP_BITS stop bits. Each bit lasts BAUD_DIV clk cycles.
// Ports:
//   clk - system clock
//   rst - synchronous active-low reset
//   bus - uart_mike_tx_if.slave (tx_data, tx_send, tx_flag_clr in; tx_flag, tx_busy out)
//   tx  - serial line, idle high, registered
module uart_mike_tx #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned BAUD_DIV   = 434,
    parameter int unsigned PARITY_EN  = 1,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic            clk,
    input  logic            rst,
    uart_mike_tx_if.slave   bus,
    output logic            tx
);
    localparam int unsigned CNT_W = 16;
    localparam int unsigned BIT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;

    localparam logic [CNT_W-1:0] CntLast  = CNT_W'(BAUD_DIV - 1);
    localparam logic [BIT_W-1:0] DataLast = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0] StopLast = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BIT_W-1:0]    bit_q, bit_d;     // data bit index in StData, stop bit index in StStop
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic                par_q, par_d;
    logic                tx_q, tx_d;
    logic                busy_q, busy_d;
    logic                flag_q, flag_d;
    logic                send_q;
    logic                start_pulse;
    logic                cnt_last;
    logic                flag_set;

    assign start_pulse = bus.tx_send & ~send_q;
    assign cnt_last    = (cnt_q == CntLast);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shreg_d  = shreg_q;
        par_d    = par_q;
        tx_d     = tx_q;
        busy_d   = busy_q;
        flag_set = 1'b0;

        // tx_d always carries the line value of the state being entered, so tx is registered
        // yet changes exactly on the bit boundary.
        unique case (state_q)
            StIdle: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (start_pulse) begin
                    state_d = StStart;
                    cnt_d   = '0;
                    bit_d   = '0;
                    shreg_d = bus.tx_data;
                    par_d   = (PARITY_ODD != 0) ? ~^bus.tx_data : ^bus.tx_data;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            StStart: begin
                if (cnt_last) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = StData;
                    tx_d    = shreg_q[0];
                    shreg_d = shreg_q >> 1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StData: begin
                if (cnt_last) begin
                    cnt_d = '0;
                    if (bit_q == DataLast) begin
                        bit_d = '0;
                        if (PARITY_EN != 0) begin
                            state_d = StParity;
                            tx_d    = par_q;
                        end else begin
                            state_d = StStop;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d   = bit_q + BIT_W'(1);
                        tx_d    = shreg_q[0];
                        shreg_d = shreg_q >> 1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StParity: begin
                if (cnt_last) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = StStop;
                    tx_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StStop: begin
                if (cnt_last) begin
                    cnt_d = '0;
                    if (bit_q == StopLast) begin
                        bit_d    = '0;
                        state_d  = StIdle;
                        tx_d     = 1'b1;
                        busy_d   = 1'b0;
                        flag_set = 1'b1;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase

        // Set beats clear so a completion is never lost.
        flag_d = flag_set | (flag_q & ~bus.tx_flag_clr);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            flag_q  <= 1'b0;
            send_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            flag_q  <= flag_d;
            send_q  <= bus.tx_send;
        end
    end

    assign tx          = tx_q;
    assign bus.tx_busy = busy_q;
    assign bus.tx_flag = flag_q;
endmodule

// File: tb/tb_uart_mike_tx.sv
// tb_uart_mike_tx: scoreboard bench for uart_mike_tx with BAUD_DIV=4.
// Three instances cover the parity/stop configurations: A even/1 stop, B odd/2 stop,
// C no parity/1 stop. Expected bytes are queued when a send is driven; per-instance
// monitors capture each frame cycle by cycle and compare it with a waveform model.
module tb_uart_mike_tx;
    localparam int unsigned BAUD = 4;

    logic clk = 1'b0;
    logic rst;
    logic tx_a, tx_b, tx_c;

    always #5 clk = ~clk;

    uart_mike_tx_if #(.DATA_W(8)) if_a ();
    uart_mike_tx_if #(.DATA_W(8)) if_b ();
    uart_mike_tx_if #(.DATA_W(8)) if_c ();

    uart_mike_tx #(.DATA_W(8), .BAUD_DIV(BAUD), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1))
        u_dut_a (.clk(clk), .rst(rst), .bus(if_a), .tx(tx_a));
    uart_mike_tx #(.DATA_W(8), .BAUD_DIV(BAUD), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2))
        u_dut_b (.clk(clk), .rst(rst), .bus(if_b), .tx(tx_b));
    uart_mike_tx #(.DATA_W(8), .BAUD_DIV(BAUD), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1))
        u_dut_c (.clk(clk), .rst(rst), .bus(if_c), .tx(tx_c));

    logic [2:0] tx_w, busy_w, flag_w;
    assign tx_w   = {tx_c, tx_b, tx_a};
    assign busy_w = {if_c.tx_busy, if_b.tx_busy, if_a.tx_busy};
    assign flag_w = {if_c.tx_flag, if_b.tx_flag, if_a.tx_flag};

    typedef struct {
        int unsigned dut;
        logic [7:0]  data;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   frames[3] = '{0, 0, 0};

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected tx waveform, one bit per clk cycle, bit 0 = first cycle of the start bit.
    function automatic logic [63:0] model_wave(input logic [7:0] data, input bit pe, input bit po,
                                               input int unsigned sb);
        logic [63:0] w;
        bit          bits[$];
        int unsigned pos;
        w   = '0;
        pos = 0;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(data[i]);
        if (pe) bits.push_back(po ? ~^data : ^data);
        for (int s = 0; s < int'(sb); s++) bits.push_back(1'b1);
        foreach (bits[j]) begin
            for (int r = 0; r < int'(BAUD); r++) begin
                w[pos] = bits[j];
                pos++;
            end
        end
        return w;
    endfunction

    task automatic monitor(input int unsigned d, input int unsigned len, input bit pe, input bit po,
                           input int unsigned sb);
        logic [63:0] wave, bwave;
        bit          aborted;
        exp_t        item;
        forever begin
            @(negedge clk);
            if (rst && tx_w[d] == 1'b0) begin
                wave     = '0;
                bwave    = '0;
                aborted  = 1'b0;
                wave[0]  = tx_w[d];
                bwave[0] = busy_w[d];
                for (int i = 1; i < int'(len); i++) begin
                    @(negedge clk);
                    if (!rst) begin
                        aborted = 1'b1;
                        break;
                    end
                    wave[i]  = tx_w[d];
                    bwave[i] = busy_w[d];
                end
                if (!aborted) begin
                    @(negedge clk);
                    frames[d]++;
                    check_eq("flag_at_end", 64'(flag_w[d]), 64'd1);
                    check_eq("tx_idle_at_end", 64'(tx_w[d]), 64'd1);
                    check_eq("busy_low_at_end", 64'(busy_w[d]), 64'd0);
                    check_eq("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
                    if (exp_q.size() != 0) begin
                        item = exp_q.pop_front();
                        check_eq("sb_dut", 64'(item.dut), 64'(d));
                        check_eq("frame_wave", wave, model_wave(item.data, pe, po, sb));
                        check_eq("frame_busy", bwave, (64'd1 << len) - 64'd1);
                    end
                end
            end
        end
    endtask

    initial monitor(0, 44, 1'b1, 1'b0, 1);
    initial monitor(1, 48, 1'b1, 1'b1, 2);
    initial monitor(2, 40, 1'b0, 1'b0, 1);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_send(input int unsigned d, input logic v);
        case (d)
            0: if_a.tx_send = v;
            1: if_b.tx_send = v;
            default: if_c.tx_send = v;
        endcase
    endtask

    task automatic set_data(input int unsigned d, input logic [7:0] v);
        case (d)
            0: if_a.tx_data = v;
            1: if_b.tx_data = v;
            default: if_c.tx_data = v;
        endcase
    endtask

    // Queue the expectation and raise tx_send; caller is then in the start cycle N.
    task automatic launch(input int unsigned d, input logic [7:0] v, input bit expect_frame);
        exp_t item;
        set_data(d, v);
        if (expect_frame) begin
            item.dut  = d;
            item.data = v;
            exp_q.push_back(item);
        end
        set_send(d, 1'b1);
    endtask

    task automatic wait_done(input string tag, input int unsigned budget);
        int unsigned n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        check_eq(tag, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0;
        int cnt;
        rst = 1'b0;
        if_a.tx_data = '0; if_a.tx_send = 1'b0; if_a.tx_flag_clr = 1'b0;
        if_b.tx_data = '0; if_b.tx_send = 1'b0; if_b.tx_flag_clr = 1'b0;
        if_c.tx_data = '0; if_c.tx_send = 1'b0; if_c.tx_flag_clr = 1'b0;
        repeat (3) step();
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check_eq("rst_tx", 64'(tx_w[d]), 64'd1);
            check_eq("rst_busy", 64'(busy_w[d]), 64'd0);
            check_eq("rst_flag", 64'(flag_w[d]), 64'd0);
        end
        step();
        rst = 1'b1;
        repeat (2) step();

        // Even parity, 0x55
        launch(0, 8'h55, 1'b1);
        step();
        set_send(0, 1'b0);
        wait_done("t1_done", 200);

        // Flag clear, single cycle
        @(negedge clk);
        check_eq("t4_flag_before_clr", 64'(if_a.tx_flag), 64'd1);
        step();
        if_a.tx_flag_clr = 1'b1;
        step();
        if_a.tx_flag_clr = 1'b0;
        @(negedge clk);
        check_eq("t4_flag_after_clr", 64'(if_a.tx_flag), 64'd0);
        step();

        // Odd parity, two stop bits
        launch(1, 8'hA3, 1'b1);
        step();
        set_send(1, 1'b0);
        wait_done("t2_done_a3", 200);
        step();
        launch(1, 8'h00, 1'b1);
        step();
        set_send(1, 1'b0);
        wait_done("t2_done_00", 200);

        // Held send: exactly one frame
        f0 = frames[0];
        launch(0, 8'h55, 1'b1);
        repeat (200) step();
        check_eq("t3_held_one_frame", 64'(frames[0] - f0), 64'd1);
        set_send(0, 1'b0);
        step();

        // Edge while busy is dropped
        f0 = frames[0];
        launch(0, 8'h55, 1'b1);
        repeat (5) step();
        set_send(0, 1'b0);
        repeat (5) step();
        set_send(0, 1'b1);
        wait_done("t3_busy_done", 200);
        repeat (60) step();
        check_eq("t3_busy_edge_ignored", 64'(frames[0] - f0), 64'd1);
        check_eq("t3_idle_busy", 64'(if_a.tx_busy), 64'd0);
        set_send(0, 1'b0);
        step();

        // Clear held across frame end: one-cycle flag pulse
        if_a.tx_flag_clr = 1'b1;
        step();
        launch(0, 8'h33, 1'b1);
        step();
        set_send(0, 1'b0);
        cnt = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (if_a.tx_flag) cnt++;
        end
        check_eq("t4_flag_pulse_len", 64'(cnt), 64'd1);
        wait_done("t4_done", 100);
        if_a.tx_flag_clr = 1'b0;
        step();

        // Mid-frame reset
        f0 = frames[0];
        launch(0, 8'hFF, 1'b0);
        repeat (20) step();
        rst = 1'b0;
        set_send(0, 1'b0);
        step();
        @(negedge clk);
        check_eq("t5_rst_tx", 64'(tx_a), 64'd1);
        check_eq("t5_rst_busy", 64'(if_a.tx_busy), 64'd0);
        check_eq("t5_rst_flag", 64'(if_a.tx_flag), 64'd0);
        step();
        rst = 1'b1;
        repeat (2) step();
        check_eq("t5_no_partial_frame", 64'(frames[0] - f0), 64'd0);

        // Data latched at start
        launch(0, 8'h0F, 1'b1);
        repeat (5) step();
        set_send(0, 1'b0);
        set_data(0, 8'h00);
        wait_done("t5_latch_done", 200);
        step();

        // No parity, back-to-back
        launch(2, 8'h01, 1'b1);
        step();
        set_send(2, 1'b0);
        set_data(2, 8'h80);
        repeat (40) step();
        launch(2, 8'h80, 1'b1);
        @(negedge clk);
        check_eq("t6_flag_first", 64'(if_c.tx_flag), 64'd1);
        check_eq("t6_gap_tx_high", 64'(tx_c), 64'd1);
        step();
        set_send(2, 1'b0);
        @(negedge clk);
        check_eq("t6_b2b_start_tx", 64'(tx_c), 64'd0);
        check_eq("t6_b2b_start_busy", 64'(if_c.tx_busy), 64'd1);
        wait_done("t6_done", 200);
        check_eq("t6_frame_count", 64'(frames[2]), 64'd2);

        repeat (5) step();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_mike_tx.md
Name: uart_mike_tx

Overview:
- UART transmit engine that sits directly downstream of the MMIO/GPIO register block.
- Consumes the registered `tx_data`, `tx_send` and `tx_flag_clr` controls and serialises one frame onto the `tx` line.
- Frame order: start bit, data bits LSB first, optional parity bit, stop bit(s).
- Returns a sticky `tx_flag` completion status that the MMIO block samples for software polling.

Parameters:
- DATA_W, 8, data bits per frame; equals UART_DATA_WIDTH.
- BAUD_DIV, 434, clk cycles per bit (50 MHz / 115200); legal range 2..65535.
- PARITY_EN, 1, 1 = parity bit inserted after data; 0 = no parity bit.
- PARITY_ODD, 0, 0 = even parity; 1 = odd parity; ignored when PARITY_EN=0.
- STOP_BITS, 1, number of stop bits; 1 or 2.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous active-low reset.
- tx_data, input, DATA_W, byte to transmit; level from the MMIO register.
- tx_send, input, 1, send request; level from the MMIO register, start triggers on rising edge only.
- tx_flag_clr, input, 1, clears `tx_flag` while high (level).
- tx, output, 1, serial line; idle high.
- tx_flag, output, 1, sticky frame-complete flag.
- tx_busy, output, 1, high while a frame is in progress.

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-low. All state updates on posedge clk only when rst=1.
- Reset values:
  - tx=1, tx_flag=0, tx_busy=0.
  - FSM = IDLE; baud counter, bit counter and shift register = 0.
  - tx_send edge register = 0. A tx_send held high across reset release therefore launches one frame.
- Start detect: start_pulse = tx_send & ~tx_send_q, where tx_send_q is tx_send registered every cycle regardless of state.
  - Start is accepted only in IDLE.
  - A rising edge while busy is dropped, not queued.
  - Holding tx_send high never retriggers.
- Latch: on an accepted start (cycle N), tx_data is captured into the shift register and the parity bit is computed.
  - Later changes to tx_data do not affect the frame in flight.
- FSM states: IDLE -> START -> DATA -> PARITY (skipped if PARITY_EN=0) -> STOP -> IDLE.
  - Each bit state lasts exactly BAUD_DIV cycles, timed by a baud counter running 0..BAUD_DIV-1.
  - The state advances when the counter reaches BAUD_DIV-1; the counter wraps to 0 on each bit boundary.
- tx is registered:
  - START drives 0 from cycle N+1.
  - DATA shifts out LSB first; the bit counter runs 0..DATA_W-1 and leaves DATA after bit DATA_W-1.
  - PARITY drives ^data when PARITY_ODD=0, or ~^data when PARITY_ODD=1.
  - STOP drives 1 for STOP_BITS*BAUD_DIV cycles.
  - IDLE drives 1.
- Frame length = (1 + DATA_W + PARITY_EN + STOP_BITS) * BAUD_DIV cycles, counted from N+1.
- tx_busy = 1 from N+1 through the last STOP cycle; 0 in IDLE.
- tx_flag:
  - Set in the cycle after the last STOP cycle, coincident with the return to IDLE.
  - Stays 1 until a cycle in which tx_flag_clr=1.
  - Simultaneous set and clear: set wins, so completion is never lost.
  - tx_flag_clr held high clears the flag every cycle except the set cycle, which yields a one-cycle pulse.
- A new start is accepted in the first IDLE cycle, i.e. back-to-back frames are allowed with zero idle bit.
- Reset asserted mid-frame:
  - Next cycle: tx=1, FSM IDLE, tx_flag=0, tx_busy=0.
  - The partial frame is abandoned with no completion flag.

Test Plan:
- Sim parameters: BAUD_DIV=4 unless stated.
- Test 1, even parity, 0x55:
  - Stimulus: PARITY_EN=1, PARITY_ODD=0, STOP_BITS=1; tx_data=0x55, tx_send 0->1 at cycle N.
  - Required: tx bit sequence 0,1,0,1,0,1,0,1,0,0(parity),1, each bit 4 cycles, tx low at N+1.
  - Required: tx_busy high for 44 cycles; tx_flag=1 at N+45.
- Test 2, odd parity, two stop bits, 0xA3:
  - Stimulus: PARITY_ODD=1, STOP_BITS=2; tx_data=0xA3.
  - Required: data bits 1,1,0,0,0,1,0,1; parity 1; stop high 8 cycles; frame 48 cycles.
- Test 3, held send and busy restart:
  - Stimulus: tx_send held high 200 cycles after a 0x55 send.
  - Required: exactly one frame.
  - Stimulus: a second rising edge at N+10 (mid-frame).
  - Required: ignored; no second frame.
- Test 4, flag clear priority:
  - Stimulus: tx_flag=1, then tx_flag_clr=1 for one cycle.
  - Required: tx_flag=0 next cycle.
  - Stimulus: tx_flag_clr held high during a frame end.
  - Required: tx_flag high exactly one cycle.
- Test 5, mid-frame reset and data latch:
  - Stimulus: rst=0 at N+20 of a 0xFF frame.
  - Required: next cycle tx=1, tx_busy=0, tx_flag=0.
  - Stimulus: after release, new send of 0x0F.
  - Required: correct full frame.
  - Stimulus: tx_data changed to 0x00 at N+5 of the 0x0F frame.
  - Required: 0x0F still transmitted.
- Test 6, no parity, back-to-back:
  - Stimulus: PARITY_EN=0; send 0x01, then toggle tx_send 0/1 so the rising edge lands on the first IDLE cycle.
  - Required: frame 40 cycles, no parity bit.
  - Required: second frame starts with no extra idle, and tx_flag set after each frame.
